pc_gen: RTL
===========

Name: pc_gen

Overview:
Parametrised next-generation program-counter unit at the head of the fetch stage. It holds the current fetch address and presents it to instruction memory over a valid/ready handshake. It selects the next PC by fixed priority from sequential, branch, jump, return and exception sources. A small circular return-address stack (RAS) predicts return targets.

Parameters:
XLEN, 32, address width in bits
RESET_VEC, 32'h00400000, PC value loaded on reset
EXC_VEC, 32'h80000180, PC value loaded on exception
INST_BYTES, 4, sequential increment; power of two
RAS_DEPTH, 4, RAS entries; power of two, >= 2

Ports:
CLK  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_addr  out  XLEN  current PC, registered
fetch_valid  out  1  fetch_addr is a valid request
fetch_ready  in  1  instruction memory accepts request
pc_hold  in  1  suppress sequential advance (hazard stall)
br_taken  in  1  branch redirect
br_target  in  XLEN  branch target
jmp_req  in  1  jump redirect
jmp_target  in  XLEN  jump target; also return fallback
ret_req  in  1  return; target from RAS top
call_req  in  1  push link_addr onto RAS
link_addr  in  XLEN  return address to push
exc_req  in  1  exception redirect
pc_plus  out  XLEN  fetch_addr + INST_BYTES, combinational
ras_empty  out  1  RAS count == 0
misalign  out  1  one-cycle pulse: last redirect target was misaligned

Behaviour:
- Clock is CLK. Reset is asynchronous and active-low on rst_n; all state is cleared while rst_n = 0.
- Reset values: fetch_addr = RESET_VEC, fetch_valid = 0, RAS count = 0, RAS top pointer = 0, misalign = 0.
- First rising edge after reset release: fetch_valid -> 1, fetch_addr unchanged. fetch_valid stays 1 until the next reset.
- Accept = fetch_valid & fetch_ready.
- Next-PC priority, evaluated every cycle, applied at the clock edge:
  - exc_req -> EXC_VEC.
  - Else br_taken -> br_target.
  - Else ret_req -> RAS top if count > 0, else jmp_target.
  - Else jmp_req -> jmp_target.
  - Else accept & !pc_hold -> fetch_addr + INST_BYTES.
  - Else hold fetch_addr.
- Redirects are taken whether or not accept or pc_hold is asserted. A redirect replaces an unaccepted request; fetch_valid stays 1.
- Redirect target alignment: low log2(INST_BYTES) bits are forced to 0 before loading. misalign = 1 for exactly the next cycle if any of those bits were nonzero. EXC_VEC is never flagged.
- Sequential add wraps modulo 2^XLEN; there is no carry-out.
- RAS is a circular buffer with a top pointer and count (0..RAS_DEPTH).
  - Push (call_req): pointer increments mod RAS_DEPTH and the entry is written. Count saturates at RAS_DEPTH; overflow overwrites the oldest entry silently.
  - Pop (ret_req with count > 0): pointer decrements and count decrements. Pop on empty: no state change; fallback target is used.
  - call_req & ret_req together: the top entry is replaced with link_addr; count unchanged. If count is 0, this is a push.
  - exc_req flushes the RAS (count = 0) and overrides a simultaneous call or return.
  - RAS updates only when the corresponding request is the selected source or is call_req. A ret_req masked by br_taken does not pop.
- Reset mid-operation: all state returns to reset values immediately, with no dependence on CLK.

Decomposition:
- pc_pkg holds:
  - enum next_src_e {NS_HOLD, NS_SEQ, NS_BR, NS_RET, NS_JMP, NS_EXC}, used for next-PC select and assertions.
  - Default constants for RESET_VEC and EXC_VEC.
- Sub-module ras_stack (parameters XLEN, RAS_DEPTH). Ports: push, pop, push_data, top, empty, flush. It owns the pointer/count logic and the overflow and simultaneous push/pop rules.

Test Plan:
- Reset release, fetch_ready=1, no redirects -> fetch_valid 0 then 1; fetch_addr 0x00400000, 0x00400004, 0x00400008 on successive cycles.
- fetch_ready=0 for 3 cycles, then br_taken with target 0x00400100 during a stall -> address held, then 0x00400100, fetch_valid stays 1, misalign=0.
- exc_req and br_taken in the same cycle -> fetch_addr 0x80000180, RAS count 0; pc_hold=1 with no redirect -> address held.
- 5 calls with link 0x10, 0x20, 0x30, 0x40, 0x50 (RAS_DEPTH=4), then 5 returns -> targets 0x50, 0x40, 0x30, 0x20, then jmp_target; ras_empty=1 after the 4th return.
- jmp_target 0x00400102 -> fetch_addr 0x00400100, misalign pulses for 1 cycle; fetch_addr 0xFFFFFFFC on a sequential accept -> wraps to 0x00000000.
- rst_n asserted between clock edges mid-sequence -> fetch_addr = 0x00400000, fetch_valid = 0 and ras_empty = 1 immediately, with no clock edge required.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and default vectors for the program-counter generator.
package pc_pkg;

    typedef enum logic [2:0] {
        NS_HOLD,
        NS_SEQ,
        NS_BR,
        NS_RET,
        NS_JMP,
        NS_EXC
    } next_src_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0180;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch request channel from the PC generator to instruction memory.
// A request is transferred on a rising edge where fetch_valid and fetch_ready are both 1;
// fetch_addr is held stable while fetch_valid=1 and fetch_ready=0 unless a redirect replaces it.
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] fetch_addr;
    logic            fetch_valid;
    logic            fetch_ready;

    modport master (output fetch_addr, output fetch_valid, input fetch_ready);
    modport slave  (input fetch_addr, input fetch_valid, output fetch_ready);
endinterface

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack: top pointer plus saturating count, oldest entry lost on overflow.
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    input  logic            flush,
    output logic [XLEN-1:0] top,
    output logic            empty
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_inc;
    logic [PW-1:0]   ptr_dec;
    logic [CW-1:0]   count;

    assign ptr_inc = ptr + 1'b1;
    assign ptr_dec = ptr - 1'b1;
    assign top     = mem[ptr];
    assign empty   = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (push && pop && !empty) begin
            // Call and return together: the returning frame is replaced by the new one.
            mem[ptr] <= push_data;
        end else if (push) begin
            ptr          <= ptr_inc;
            mem[ptr_inc] <= push_data;
            if (count != CW'(RAS_DEPTH)) count <= count + 1'b1;
        end else if (pop && !empty) begin
            ptr   <= ptr_dec;
            count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: fixed-priority next-PC select with a return-address stack.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] EXC_VEC    = XLEN'(DEF_EXC_VEC),
    parameter int              INST_BYTES = 4,
    parameter int              RAS_DEPTH  = 4
) (
    input  logic            CLK,
    input  logic            rst_n,
    pc_gen_if.master        fetch,
    input  logic            pc_hold,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            jmp_req,
    input  logic [XLEN-1:0] jmp_target,
    input  logic            ret_req,
    input  logic            call_req,
    input  logic [XLEN-1:0] link_addr,
    input  logic            exc_req,
    output logic [XLEN-1:0] pc_plus,
    output logic            ras_empty,
    output logic            misalign
);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);

    logic [XLEN-1:0] pc_q;
    logic            valid_q;
    logic            mis_q;
    next_src_e       src;
    logic [XLEN-1:0] raw_target;
    logic [XLEN-1:0] next_pc;
    logic            next_mis;
    logic [XLEN-1:0] ras_top;
    logic            accept;

    assign fetch.fetch_addr  = pc_q;
    assign fetch.fetch_valid = valid_q;
    assign accept            = valid_q & fetch.fetch_ready;
    assign pc_plus           = pc_q + XLEN'(INST_BYTES);
    assign misalign          = mis_q;

    always_comb begin
        src        = NS_HOLD;
        raw_target = '0;
        next_pc    = pc_q;
        next_mis   = 1'b0;
        // The first cycle out of reset only raises fetch_valid; no source is selected yet.
        if (valid_q) begin
            if (exc_req)                 src = NS_EXC;
            else if (br_taken)           src = NS_BR;
            else if (ret_req)            src = NS_RET;
            else if (jmp_req)            src = NS_JMP;
            else if (accept && !pc_hold) src = NS_SEQ;
        end
        case (src)
            NS_BR:   raw_target = br_target;
            NS_RET:  raw_target = ras_empty ? jmp_target : ras_top;
            NS_JMP:  raw_target = jmp_target;
            default: raw_target = '0;
        endcase
        case (src)
            NS_EXC:                next_pc = EXC_VEC;
            NS_BR, NS_RET, NS_JMP: begin
                next_pc  = raw_target & ~ALIGN_MASK;
                next_mis = |(raw_target & ALIGN_MASK);
            end
            NS_SEQ:                next_pc = pc_plus;
            default:               next_pc = pc_q;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= next_pc;
            valid_q <= 1'b1;
            mis_q   <= next_mis;
        end
    end

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (CLK),
        .rst_n     (rst_n),
        .push      (call_req & valid_q & ~exc_req),
        .pop       (src == NS_RET),
        .push_data (link_addr),
        .flush     (src == NS_EXC),
        .top       (ras_top),
        .empty     (ras_empty)
    );
endmodule
